tx_sr_buffered: RTL and testbench

Parametrised, double-buffered parallel-to-serial transmit shift register. It is the next generation of the transmit serializer: configurable word width and bit order, a one-entry holding register with a valid/ready handshake, and a bit counter that chains words back-to-back with no idle bit between them. It sits between the packet/encryption datapath (word producer) and the line encoder, which supplies the bit-rate strobe.

---
 rtl/tx_sr_buffered.sv | 124 ++++++++++++
 tb/tb_tx_sr_buffered.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sr_buffered.sv
// tx_sr_buffered: double-buffered parallel-to-serial transmit shifter.
// A one-entry holding register decouples the word producer from the shifter,
// so a new word can be loaded on the same edge that consumes the last bit of
// the previous one, giving gapless back-to-back words on the line.
//
// Handshake: data_ready is high exactly when the holding register is empty;
// a word transfers on any rising clk edge where data_valid && data_ready.
// The producer keeps data_in stable while data_valid is high and not yet taken.
module tx_sr_buffered #(
  parameter int DATA_WIDTH = 128,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_VAL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_strobe,
  input  logic                  tx_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  word_done,
  output logic                  state_dbg
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] hold_reg_q, hold_reg_n;
  logic                  hold_full_q, hold_full_n;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_n;
  logic                  word_done_q, word_done_n;

  logic accept;
  logic shift_ok;
  logic [DATA_WIDTH-1:0] shreg_shifted;

  assign accept   = data_valid && !hold_full_q;
  assign shift_ok = bit_strobe && tx_enable;

  // Output end is the MSB or LSB; the vacated end fills with the idle level.
  assign shreg_shifted = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], IDLE_VAL}
                                   : {IDLE_VAL, shreg_q[DATA_WIDTH-1:1]};

  // State and datapath registers; reset discards both in-flight and held words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_reg_q  <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= {DATA_WIDTH{IDLE_VAL}};
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      hold_reg_q  <= hold_reg_n;
      hold_full_q <= hold_full_n;
      shreg_q     <= shreg_n;
      bit_cnt_q   <= bit_cnt_n;
      word_done_q <= word_done_n;
    end
  end

  // Next-state logic: load/shift/reload plus holding-register accept.
  always_comb begin
    state_n     = state_q;
    hold_reg_n  = hold_reg_q;
    hold_full_n = hold_full_q;
    shreg_n     = shreg_q;
    bit_cnt_n   = bit_cnt_q;
    word_done_n = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Strobes are ignored here, including on the load edge itself.
        if (hold_full_q) begin
          shreg_n     = hold_reg_q;
          hold_full_n = 1'b0;
          bit_cnt_n   = '0;
          state_n     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_ok) begin
          if (bit_cnt_q != LAST_BIT) begin
            shreg_n   = shreg_shifted;
            bit_cnt_n = bit_cnt_q + CW'(1);
          end else begin
            word_done_n = 1'b1;
            if (hold_full_q) begin
              shreg_n     = hold_reg_q;
              hold_full_n = 1'b0;
              bit_cnt_n   = '0;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // An accept needs an empty holder and a transfer needs a full one,
    // so these never collide on the same edge.
    if (accept) begin
      hold_reg_n  = data_in;
      hold_full_n = 1'b1;
    end
  end

  assign data_ready = !hold_full_q;
  assign tx_busy    = (state_q == S_SHIFT);
  assign word_done  = word_done_q;
  assign state_dbg  = state_q;
  assign tx_out     = (state_q == S_SHIFT)
                      ? (MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0])
                      : IDLE_VAL;

endmodule

// File: tb/tb_tx_sr_buffered.sv
// Bench for tx_sr_buffered: three instances (8-bit MSB-first, 8-bit LSB-first,
// 128-bit MSB-first) checked every cycle against a word/bit-count model.
module tb_tx_sr_buffered;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit_strobe = 1'b0;
  logic tx_enable = 1'b1;
  logic [127:0] din [3];
  logic dv [3];
  logic rdy [3];
  logic txo [3];
  logic busy [3];
  logic done [3];
  logic st [3];

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int per = 4;
  int dcnt [3];
  logic [127:0] cap [3];

  tx_sr_buffered #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u_msb8 (
    .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .tx_enable(tx_enable),
    .data_in(din[0][7:0]), .data_valid(dv[0]), .data_ready(rdy[0]),
    .tx_out(txo[0]), .tx_busy(busy[0]), .word_done(done[0]), .state_dbg(st[0]));

  tx_sr_buffered #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) u_lsb8 (
    .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .tx_enable(tx_enable),
    .data_in(din[1][7:0]), .data_valid(dv[1]), .data_ready(rdy[1]),
    .tx_out(txo[1]), .tx_busy(busy[1]), .word_done(done[1]), .state_dbg(st[1]));

  tx_sr_buffered #(.DATA_WIDTH(128), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u_msb128 (
    .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .tx_enable(tx_enable),
    .data_in(din[2]), .data_valid(dv[2]), .data_ready(rdy[2]),
    .tx_out(txo[2]), .tx_busy(busy[2]), .word_done(done[2]), .state_dbg(st[2]));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance holds: the word on the line with the number of its bits
  // still to go, a one-word holding slot, and last edge's done flag.
  logic [127:0] m_cur [3];
  logic [127:0] m_hw [3];
  int           m_n [3];
  logic         m_hv [3];
  logic         m_done [3];

  function automatic int dw(input int i);
    return (i == 2) ? 128 : 8;
  endfunction

  function automatic logic exp_tx(input int i);
    int idx;
    if (m_n[i] == 0) return 1'b1;
    idx = (i == 1) ? (dw(i) - m_n[i]) : (m_n[i] - 1);
    return m_cur[i][idx];
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = '0; m_hw[i] = '0; m_n[i] = 0; m_hv[i] = 1'b0; m_done[i] = 1'b0;
      dcnt[i] = 0; cap[i] = '0; din[i] = '0; dv[i] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          m_n[i] = 0; m_hv[i] = 1'b0; m_done[i] = 1'b0;
        end else begin
          logic ok, hv, acc;
          ok  = bit_strobe && tx_enable;
          hv  = m_hv[i];
          acc = dv[i] && !hv;
          m_done[i] = 1'b0;
          if (m_n[i] > 0) begin
            if (ok) begin
              m_n[i]--;
              if (m_n[i] == 0) begin
                m_done[i] = 1'b1;
                if (hv) begin
                  m_cur[i] = m_hw[i]; m_n[i] = dw(i); m_hv[i] = 1'b0;
                end
              end
            end
          end else if (hv) begin
            m_cur[i] = m_hw[i]; m_n[i] = dw(i); m_hv[i] = 1'b0;
          end
          if (acc) begin
            m_hw[i] = din[i]; m_hv[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  // Samples 2 time units after the falling edge, once drivers have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ready%0d", i), rdy[i], !m_hv[i]);
        check($sformatf("tx_out%0d", i), txo[i], exp_tx(i));
        check($sformatf("busy%0d", i), busy[i], m_n[i] > 0);
        check($sformatf("state%0d", i), st[i], m_n[i] > 0);
        check($sformatf("done%0d", i), done[i], m_done[i]);
        if (bit_strobe && tx_enable && m_n[i] > 0 && !rst)
          cap[i] = {cap[i][126:0], txo[i]};
        if (done[i]) dcnt[i]++;
      end
    end
  end

  // ---------------- strobe generator ----------------
  initial begin
    int sc = 0;
    forever begin
      @(negedge clk);
      if (per == 0) begin
        bit_strobe = ($urandom_range(0, 3) == 0);
      end else begin
        sc++;
        bit_strobe = (sc >= per);
        if (bit_strobe) sc = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Leaves data_valid high after the accept so callers can chain words.
  task automatic push(input int i, input logic [127:0] w, output int waited);
    logic r;
    waited = 0;
    @(negedge clk);
    din[i] = w;
    dv[i] = 1'b1;
    forever begin
      r = rdy[i];
      @(negedge clk);
      if (r) break;
      waited++;
      if (waited > 3000) begin
        check($sformatf("push_timeout%0d", i), 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while (m_n[i] != 0 || m_hv[i]) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        check($sformatf("idle_timeout%0d", i), 0, 1);
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_left(input int i, input int n);
    int t = 0;
    while (m_n[i] != n) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        check($sformatf("left_timeout%0d", i), 0, 1);
        break;
      end
    end
  endtask

  task automatic rand_traffic(input int i, input int words);
    int w;
    repeat (words) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      push(i, {$urandom, $urandom, $urandom, $urandom}, w);
      if ($urandom_range(0, 1) == 1) dv[i] = 1'b0;
    end
    @(negedge clk);
    dv[i] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, w, wb;
    logic save;
    logic [127:0] big;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_out", txo[0], 1'b1);
    check("rst_ready", rdy[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // single word, MSB first
    d0 = dcnt[0];
    push(0, 128'hA5, w); dv[0] = 1'b0;
    wait_idle(0);
    check("a5_msb_seq", cap[0][7:0], 8'hA5);
    check("a5_msb_done", dcnt[0] - d0, 1);

    // LSB first
    d0 = dcnt[1];
    push(1, 128'hA5, w); dv[1] = 1'b0;
    wait_idle(1);
    check("a5_lsb_seq", cap[1][7:0], 8'hA5);
    push(1, 128'h01, w); dv[1] = 1'b0;
    wait_idle(1);
    check("01_lsb_seq", cap[1][7:0], 8'h80);
    check("lsb_done", dcnt[1] - d0, 2);

    // back-to-back with backpressure
    d0 = dcnt[0];
    push(0, 128'hF0, w);
    push(0, 128'h0F, w);
    push(0, 128'hC3, wb);
    dv[0] = 1'b0;
    check("b2b_backpressure", wb > 0, 1'b1);
    wait_idle(0);
    check("b2b_seq", cap[0][23:0], 24'hF00FC3);
    check("b2b_done", dcnt[0] - d0, 3);

    // tx_enable gating mid-word
    push(0, 128'h6B, w); dv[0] = 1'b0;
    wait_left(0, 5);
    tx_enable = 1'b0;
    @(negedge clk);
    save = txo[0];
    repeat (40) @(negedge clk);
    check("gate_freeze", txo[0], save);
    tx_enable = 1'b1;
    wait_idle(0);
    check("gate_seq", cap[0][7:0], 8'h6B);

    // reset mid-word with a held word
    push(0, 128'h3C, w); dv[0] = 1'b0;
    wait_left(0, 4);
    push(0, 128'h99, w); dv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx_out", txo[0], 1'b1);
    check("midrst_ready", rdy[0], 1'b1);
    check("midrst_busy", busy[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_residue", busy[0], 1'b0);
    d0 = dcnt[0];
    push(0, 128'h81, w); dv[0] = 1'b0;
    wait_idle(0);
    check("midrst_81_seq", cap[0][7:0], 8'h81);
    check("midrst_81_done", dcnt[0] - d0, 1);

    // default width
    per = 1;
    big = {$urandom, $urandom, $urandom, $urandom};
    d0 = dcnt[2];
    push(2, big, w); dv[2] = 1'b0;
    wait_idle(2);
    check("w128_seq", cap[2], big);
    check("w128_done", dcnt[2] - d0, 1);

    // randomized traffic on all instances
    per = 0;
    fork
      rand_traffic(0, 20);
      rand_traffic(1, 20);
      rand_traffic(2, 3);
      begin
        repeat (400) begin
          @(negedge clk);
          tx_enable = ($urandom_range(0, 7) != 0);
        end
        tx_enable = 1'b1;
      end
    join
    tx_enable = 1'b1;
    wait_idle(0);
    wait_idle(1);
    wait_idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
